// File: rtl/alu_pkg.sv
// alu_pkg: op codes and FSM state encoding shared by the sequential ALU
package alu_pkg;
    localparam logic [1:0] OP_ADD = 2'b00;
    localparam logic [1:0] OP_SUB = 2'b01;
    localparam logic [1:0] OP_MUL = 2'b10;
    localparam logic [1:0] OP_DIV = 2'b11;
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;
endpackage

// File: rtl/alu_iter_unit.sv
// alu_iter_unit: WIDTH-step shift-add multiplier / restoring divider datapath
module alu_iter_unit #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             div,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic [WIDTH-1:0] hi_nx,
    output logic [WIDTH-1:0] lo_nx,
    output logic             last
);
    localparam int CW = $clog2(WIDTH + 1);
    logic [WIDTH-1:0] hi_q, hi_d, lo_q, lo_d, m_q, m_d, sub;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             div_q, div_d, run, fit;
    logic [WIDTH:0]   add, rem;
    // lo holds the multiplier (MUL) or the dividend shifting into the quotient (DIV)
    always_comb begin
        run   = cnt_q != '0;
        add   = {1'b0, hi_q} + (lo_q[0] ? {1'b0, m_q} : '0);
        rem   = {hi_q, lo_q[WIDTH-1]};
        fit   = rem >= {1'b0, m_q};
        sub   = rem[WIDTH-1:0] - m_q;
        hi_nx = div_q ? (fit ? sub : rem[WIDTH-1:0]) : add[WIDTH:1];
        lo_nx = div_q ? {lo_q[WIDTH-2:0], fit} : {add[0], lo_q[WIDTH-1:1]};
        hi_d  = start ? '0 : run ? hi_nx : hi_q;
        lo_d  = start ? (div ? a : b) : run ? lo_nx : lo_q;
        m_d   = start ? (div ? b : a) : m_q;
        div_d = start ? div : div_q;
        cnt_d = start ? CW'(WIDTH) : run ? cnt_q - 1'b1 : cnt_q;
        last  = cnt_q == CW'(1);
    end
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            hi_q  <= '0;
            lo_q  <= '0;
            m_q   <= '0;
            div_q <= 1'b0;
            cnt_q <= '0;
        end else begin
            hi_q  <= hi_d;
            lo_q  <= lo_d;
            m_q   <= m_d;
            div_q <= div_d;
            cnt_q <= cnt_d;
        end
    end
endmodule

// File: rtl/alu_seq.sv
// alu_seq: multi-cycle unsigned ADD/SUB/MUL/DIV with valid/ready handshake
module alu_seq import alu_pkg::*; #(
    parameter int WIDTH = 8
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [2*WIDTH-1:0] in,
    input  logic [1:0]         op_codes,
    input  logic               valid,
    output logic [WIDTH-1:0]   o,
    output logic [WIDTH-1:0]   o_ext,
    output logic               ready,
    output logic               busy,
    output logic               carry,
    output logic               zero,
    output logic               err
);
    state_t           st_q, st_d;
    logic [1:0]       op_q, op_d;
    logic [WIDTH-1:0] o_q, o_d, o_ext_q, o_ext_d, a, b, hi_nx, lo_nx;
    logic             ready_q, ready_d, busy_q, busy_d, carry_q, carry_d;
    logic             zero_q, zero_d, err_q, err_d, start, last;
    logic [WIDTH:0]   sum, dif;
    assign a = in[2*WIDTH-1:WIDTH];
    assign b = in[WIDTH-1:0];
    alu_iter_unit #(.WIDTH(WIDTH)) u_iter (
        .clk   (clk),
        .rst   (rst),
        .start (start),
        .div   (op_codes[0]),
        .a     (a),
        .b     (b),
        .hi_nx (hi_nx),
        .lo_nx (lo_nx),
        .last  (last)
    );
    // DONE lasts two cycles: one to raise ready, one to drop it and release busy
    always_comb begin
        sum     = {1'b0, a} + {1'b0, b};
        dif     = {1'b0, a} - {1'b0, b};
        st_d    = st_q;
        op_d    = op_q;
        o_d     = o_q;
        o_ext_d = o_ext_q;
        ready_d = 1'b0;
        busy_d  = busy_q;
        carry_d = carry_q;
        zero_d  = zero_q;
        err_d   = err_q;
        start   = 1'b0;
        case (st_q)
            ST_IDLE: if (valid) begin
                busy_d = 1'b1;
                op_d   = op_codes;
                start  = op_codes == OP_MUL || (op_codes == OP_DIV && b != '0);
                st_d   = start ? ST_RUN : ST_DONE;
                if (!start) begin
                    o_d     = op_codes == OP_ADD ? sum[WIDTH-1:0] :
                              op_codes == OP_SUB ? dif[WIDTH-1:0] : '1;
                    o_ext_d = op_codes == OP_DIV ? a : '0;
                    carry_d = op_codes == OP_ADD ? sum[WIDTH] : op_codes == OP_SUB && dif[WIDTH];
                    err_d   = op_codes == OP_DIV;
                    zero_d  = op_codes == OP_ADD ? sum[WIDTH-1:0] == '0 :
                              op_codes == OP_SUB && dif[WIDTH-1:0] == '0;
                end
            end
            ST_RUN: if (last) begin
                st_d    = ST_DONE;
                o_d     = lo_nx;
                o_ext_d = hi_nx;
                carry_d = 1'b0;
                err_d   = 1'b0;
                zero_d  = lo_nx == '0 && (op_q == OP_DIV || hi_nx == '0);
            end
            ST_DONE: begin
                ready_d = !ready_q;
                busy_d  = !ready_q;
                st_d    = ready_q ? ST_IDLE : ST_DONE;
            end
            default: st_d = ST_IDLE;
        endcase
    end
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            st_q    <= ST_IDLE;
            op_q    <= OP_ADD;
            o_q     <= '0;
            o_ext_q <= '0;
            ready_q <= 1'b0;
            busy_q  <= 1'b0;
            carry_q <= 1'b0;
            zero_q  <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            st_q    <= st_d;
            op_q    <= op_d;
            o_q     <= o_d;
            o_ext_q <= o_ext_d;
            ready_q <= ready_d;
            busy_q  <= busy_d;
            carry_q <= carry_d;
            zero_q  <= zero_d;
            err_q   <= err_d;
        end
    end
    assign o     = o_q;
    assign o_ext = o_ext_q;
    assign ready = ready_q;
    assign busy  = busy_q;
    assign carry = carry_q;
    assign zero  = zero_q;
    assign err   = err_q;
endmodule

// File: tb/tb_alu_seq.sv
// tb_alu_seq: scoreboard bench for alu_seq at WIDTH=8 and WIDTH=16
`timescale 1ns/1ns
module tb_alu_seq;
    import alu_pkg::*;
    typedef struct {
        logic [31:0] o, ext, t;
        logic        c, z, e;
        int          lat;
        string       name;
    } exp_t;
    exp_t q8[$], q16[$];
    exp_t m8, m16;
    int checks = 0, errors = 0;
    logic clk = 1'b0, rst = 1'b1;
    logic [15:0] in8 = '0;
    logic [31:0] in16 = '0;
    logic [1:0] op8 = '0, op16 = '0;
    logic valid8 = 1'b0, valid16 = 1'b0;
    logic [7:0] o8, ext8;
    logic [15:0] o16, ext16;
    logic ready8, busy8, carry8, zero8, err8, prev8 = 1'b0;
    logic ready16, busy16, carry16, zero16, err16, prev16 = 1'b0;
    always #5 clk = ~clk;
    alu_seq #(.WIDTH(8)) dut8 (
        .clk(clk), .rst(rst), .in(in8), .op_codes(op8), .valid(valid8),
        .o(o8), .o_ext(ext8), .ready(ready8), .busy(busy8),
        .carry(carry8), .zero(zero8), .err(err8)
    );
    alu_seq #(.WIDTH(16)) dut16 (
        .clk(clk), .rst(rst), .in(in16), .op_codes(op16), .valid(valid16),
        .o(o16), .o_ext(ext16), .ready(ready16), .busy(busy16),
        .carry(carry16), .zero(zero16), .err(err16)
    );
    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got %0d expected %0d", name, act, exp);
        end
    endtask
    task automatic score(input exp_t e, input logic [31:0] o, input logic [31:0] ext,
                         input logic c, input logic z, input logic er, input logic bz);
        chk({e.name, " o"}, o, e.o);
        chk({e.name, " o_ext"}, ext, e.ext);
        chk({e.name, " carry"}, 32'(c), 32'(e.c));
        chk({e.name, " zero"}, 32'(z), 32'(e.z));
        chk({e.name, " err"}, 32'(er), 32'(e.e));
        chk({e.name, " busy"}, 32'(bz), 32'd1);
        chk({e.name, " ready_time"}, 32'($time), e.t + 32'(10 * e.lat + 9));
    endtask
    always @(negedge clk) begin
        if (ready8 && prev8) chk("ready8 one cycle", 32'd1, 32'd0);
        if (ready8) begin
            if (q8.size() == 0) chk("ready8 unexpected", 32'd1, 32'd0);
            else begin
                m8 = q8.pop_front();
                score(m8, 32'(o8), 32'(ext8), carry8, zero8, err8, busy8);
            end
        end
        prev8 = ready8;
    end
    always @(negedge clk) begin
        if (ready16 && prev16) chk("ready16 one cycle", 32'd1, 32'd0);
        if (ready16) begin
            if (q16.size() == 0) chk("ready16 unexpected", 32'd1, 32'd0);
            else begin
                m16 = q16.pop_front();
                score(m16, 32'(o16), 32'(ext16), carry16, zero16, err16, busy16);
            end
        end
        prev16 = ready16;
    end
    task automatic push(input int w, input logic [31:0] o, input logic [31:0] ext, input logic c,
                        input logic z, input logic e, input int lat, input string name);
        exp_t x;
        x.o = o; x.ext = ext; x.c = c; x.z = z; x.e = e; x.lat = lat; x.name = name;
        x.t = 32'($time);
        if (w == 8) q8.push_back(x);
        else q16.push_back(x);
    endtask
    task automatic wait_idle8(input string name);
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (!busy8) return;
        end
        chk({name, " timeout busy8"}, 32'd1, 32'd0);
    endtask
    task automatic issue8(input logic [7:0] a, input logic [7:0] b, input logic [1:0] op,
                          input logic [31:0] o, input logic [31:0] ext, input logic c,
                          input logic z, input logic e, input int lat, input string name);
        @(negedge clk);
        #1;
        in8 = {a, b}; op8 = op; valid8 = 1'b1;
        push(8, o, ext, c, z, e, lat, name);
        @(negedge clk);
        #1;
        valid8 = 1'b0; in8 = 16'($urandom); op8 = 2'($urandom);
        wait_idle8(name);
    endtask
    task automatic chk_zero8(input string name);
        chk({name, " o"}, 32'(o8), 32'd0);
        chk({name, " o_ext"}, 32'(ext8), 32'd0);
        chk({name, " ready"}, 32'(ready8), 32'd0);
        chk({name, " busy"}, 32'(busy8), 32'd0);
        chk({name, " flags"}, 32'({carry8, zero8, err8}), 32'd0);
    endtask
    initial begin
        int n;
        repeat (2) @(negedge clk);
        chk_zero8("reset8");
        chk("reset16 outs", 32'({o16, ext16}), 32'd0);
        chk("reset16 ctl", 32'({ready16, busy16, carry16, zero16, err16}), 32'd0);
        #1 rst = 1'b0;
        issue8(8'd25, 8'd17, OP_ADD, 42, 0, 0, 0, 0, 1, "add 25+17");
        issue8(8'd200, 8'd100, OP_ADD, 44, 0, 1, 0, 0, 1, "add 200+100");
        issue8(8'd255, 8'd1, OP_ADD, 0, 0, 1, 1, 0, 1, "add 255+1");
        issue8(8'd40, 8'd15, OP_SUB, 25, 0, 0, 0, 0, 1, "sub 40-15");
        issue8(8'd15, 8'd40, OP_SUB, 231, 0, 1, 0, 0, 1, "sub 15-40");
        issue8(8'd9, 8'd9, OP_SUB, 0, 0, 0, 1, 0, 1, "sub 9-9");
        issue8(8'd200, 8'd3, OP_MUL, 88, 2, 0, 0, 0, 9, "mul 200*3");
        issue8(8'd255, 8'd255, OP_MUL, 1, 254, 0, 0, 0, 9, "mul 255*255");
        issue8(8'd0, 8'd77, OP_MUL, 0, 0, 0, 1, 0, 9, "mul 0*77");
        issue8(8'd20, 8'd4, OP_DIV, 5, 0, 0, 0, 0, 9, "div 20/4");
        issue8(8'd23, 8'd5, OP_DIV, 4, 3, 0, 0, 0, 9, "div 23/5");
        issue8(8'd5, 8'd9, OP_DIV, 0, 5, 0, 1, 0, 9, "div 5/9");
        issue8(8'd255, 8'd1, OP_DIV, 255, 0, 0, 0, 0, 9, "div 255/1");
        issue8(8'd7, 8'd0, OP_DIV, 255, 7, 0, 0, 1, 1, "div 7/0");
        // ADD requests held high through RUN and DONE of a MUL must be ignored
        @(negedge clk);
        #1;
        in8 = {8'd13, 8'd11}; op8 = OP_MUL; valid8 = 1'b1;
        push(8, 143, 0, 0, 0, 0, 9, "mul 13*11 hs");
        @(negedge clk);
        #1;
        in8 = {8'd1, 8'd2}; op8 = OP_ADD;
        n = 0;
        for (int i = 0; i < 40 && busy8; i++) begin
            @(negedge clk);
            if (busy8) n++;
        end
        #1 valid8 = 1'b0;
        chk("hs busy cycles", 32'(n), 32'd9);
        // asynchronous reset four cycles into a MUL
        @(negedge clk);
        #1;
        in8 = {8'd100, 8'd100}; op8 = OP_MUL; valid8 = 1'b1;
        @(negedge clk);
        #1 valid8 = 1'b0;
        #37 rst = 1'b1;
        #1 chk_zero8("mid reset");
        @(negedge clk);
        #1 rst = 1'b0;
        repeat (12) @(negedge clk);
        chk_zero8("after abort");
        issue8(8'd1, 8'd1, OP_ADD, 2, 0, 0, 0, 0, 1, "add 1+1");
        @(negedge clk);
        #1;
        in16 = {16'd300, 16'd300}; op16 = OP_MUL; valid16 = 1'b1;
        push(16, 24464, 1, 0, 0, 0, 17, "mul16 300*300");
        @(negedge clk);
        #1 valid16 = 1'b0;
        n = 0;
        while (busy16 && n < 100) begin
            @(negedge clk);
            n++;
        end
        chk("mul16 busy cycles", 32'(n), 32'd18);
        repeat (3) @(negedge clk);
        chk("q8 drained", 32'(q8.size()), 32'd0);
        chk("q16 drained", 32'(q16.size()), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
